// File: rtl/dds_phase_reader.sv
// dds_phase_reader
//   Sample engine for a DDS waveform generator. A prescaler produces one
//   tick every SAMPLE_DIV clocks; on each tick the phase accumulator advances
//   by the tuning word and its top 10 bits are registered onto rom_addr.
//   One cycle later (FETCH) the combinational sine ROM output, or a waveform
//   derived from the address, is registered onto sample with a one-cycle
//   sample_valid strobe.
//
//   Build option: define DDS_WAVE_SEL_EN to build the square / sawtooth /
//   triangle mux selected by wave_sel. Without it wave_sel is ignored and
//   sample always carries rom_data.
//
// Parameters
//   ACC_W       phase accumulator width (>= 10)
//   SAMPLE_DIV  clk cycles per sample period (>= 2)
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   en            run enable for the sample prescaler
//   tw_load       load tw_in into the tuning-word register
//   tw_in         tuning word (phase increment per sample)
//   phase_clr     synchronous clear of phase, prescaler and in-flight fetch
//   wave_sel      0 sine, 1 square, 2 sawtooth, 3 triangle
//   rom_addr      registered sine ROM address
//   rom_data      sine ROM data, combinational from rom_addr
//   sample        registered output sample (unsigned)
//   sample_valid  one-cycle pulse when sample updates
//   wrap          high during the FETCH cycle of a sample whose add overflowed
module dds_phase_reader #(
  parameter int ACC_W      = 24,
  parameter int SAMPLE_DIV = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tw_load,
  input  logic [ACC_W-1:0] tw_in,
  input  logic             phase_clr,
  input  logic [1:0]       wave_sel,
  output logic [9:0]       rom_addr,
  input  logic [9:0]       rom_data,
  output logic [9:0]       sample,
  output logic             sample_valid,
  output logic             wrap
);

  localparam int CNT_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAMPLE_DIV - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] tw;
  logic [CNT_W-1:0] div_cnt;
  logic             tick;
  logic [ACC_W:0]   acc_sum;
  logic [9:0]       wave;

  assign tick    = en & (div_cnt == CNT_MAX);
  // One extra bit on the add so the carry out becomes the wrap flag.
  assign acc_sum = {1'b0, acc} + {1'b0, tw};

`ifdef DDS_WAVE_SEL_EN
  always_comb begin
    wave = rom_data;
    case (wave_sel)
      2'd0: wave = rom_data;
      2'd1: wave = rom_addr[9] ? 10'h3FF : 10'h000;
      2'd2: wave = rom_addr;
      // Rising ramp over the first half-cycle, mirrored over the second.
      2'd3: wave = rom_addr[9] ? ~{rom_addr[8:0], 1'b0} : {rom_addr[8:0], 1'b0};
      default: wave = rom_data;
    endcase
  end
`else
  logic unused_wave_sel;
  assign unused_wave_sel = ^wave_sel;
  assign wave            = rom_data;
`endif

  // Sample prescaler: free-runs while en is high, holds while it is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (phase_clr) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= (div_cnt == CNT_MAX) ? '0 : div_cnt + CNT_W'(1);
    end
  end

  // Tuning word. A load coinciding with a tick takes effect after it, so
  // that tick still steps by the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tw <= '0;
    end else if (tw_load) begin
      tw <= tw_in;
    end
  end

  // Accumulate on tick (IDLE), then capture the ROM word one full cycle
  // after the address changed (FETCH).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      acc          <= '0;
      rom_addr     <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      wrap         <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (phase_clr) begin
        // Aborts any fetch in flight; sample keeps its last value.
        state    <= IDLE;
        acc      <= '0;
        rom_addr <= '0;
        wrap     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (tick) begin
              acc      <= acc_sum[ACC_W-1:0];
              wrap     <= acc_sum[ACC_W];
              rom_addr <= acc_sum[ACC_W-1 -: 10];
              state    <= FETCH;
            end
          end
          FETCH: begin
            sample       <= wave;
            sample_valid <= 1'b1;
            wrap         <= 1'b0;
            state        <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_phase_reader.sv
// tb_dds_phase_reader
//   Bench for dds_phase_reader with ACC_W = 24, SAMPLE_DIV = 4 and a
//   1024-entry sine table standing in for the ROM. A sample-level model
//   (phase = running sum of tuning words, output two edges after each tick)
//   predicts rom_addr / sample / sample_valid / wrap, and one compare
//   process checks them every cycle. Directed sections pin the model with
//   hand-computed addresses and waveform values; a randomized section then
//   mixes enable, loads, clears and waveform selects.
module tb_dds_phase_reader;

  localparam int ACC_W      = 24;
  localparam int SAMPLE_DIV = 4;
  localparam longint PHASE_MOD = longint'(1) << ACC_W;
  localparam longint ADDR_DIV  = longint'(1) << (ACC_W - 10);

  logic             clk       = 1'b0;
  logic             rst       = 1'b1;
  logic             en        = 1'b1;
  logic             tw_load   = 1'b0;
  logic [ACC_W-1:0] tw_in     = '0;
  logic             phase_clr = 1'b0;
  logic [1:0]       wave_sel  = 2'd0;
  logic [9:0]       rom_addr;
  logic [9:0]       rom_data;
  logic [9:0]       sample;
  logic             sample_valid;
  logic             wrap;

  logic [9:0] rom_mem [1024];

  int checks = 0;
  int errors = 0;
  int cyc_no = 0;

  always #5 clk = ~clk;

  assign rom_data = rom_mem[rom_addr];

  dds_phase_reader #(
    .ACC_W      (ACC_W),
    .SAMPLE_DIV (SAMPLE_DIV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .tw_load      (tw_load),
    .tw_in        (tw_in),
    .phase_clr    (phase_clr),
    .wave_sel     (wave_sel),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .sample       (sample),
    .sample_valid (sample_valid),
    .wrap         (wrap)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc_no);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [ACC_W-1:0] m_phase;
  logic [ACC_W-1:0] m_tw;
  int               m_cnt;
  bit               m_pend;
  logic [9:0]       e_addr;
  logic [9:0]       e_sample;
  bit               e_valid;
  bit               e_wrap;

  function automatic logic [9:0] wave_of(input logic [1:0] sel, input int a, input logic [9:0] d);
`ifdef DDS_WAVE_SEL_EN
    case (sel)
      2'd1: return (a >= 512) ? 10'd1023 : 10'd0;
      2'd2: return 10'(a);
      2'd3: return (a < 512) ? 10'(2 * a) : 10'(1023 - 2 * (a - 512));
      default: return d;
    endcase
`else
    if (sel > 2'd3 || a < 0) return 10'd0;
    return d;
`endif
  endfunction

  task automatic reset_model();
    m_phase  = '0;
    m_tw     = '0;
    m_cnt    = 0;
    m_pend   = 1'b0;
    e_addr   = '0;
    e_sample = '0;
    e_valid  = 1'b0;
    e_wrap   = 1'b0;
  endtask

  task automatic model_edge();
    longint s;
    if (phase_clr) begin
      m_phase = '0;
      m_cnt   = 0;
      m_pend  = 1'b0;
      e_addr  = '0;
      e_wrap  = 1'b0;
      e_valid = 1'b0;
    end else begin
      e_valid = 1'b0;
      if (m_pend) begin
        // The sample for the last tick appears one edge after the address.
        e_sample = wave_of(wave_sel, int'(e_addr), rom_mem[e_addr]);
        e_valid  = 1'b1;
        e_wrap   = 1'b0;
        m_pend   = 1'b0;
      end else if (en && m_cnt == SAMPLE_DIV - 1) begin
        s       = longint'(m_phase) + longint'(m_tw);
        e_wrap  = (s >= PHASE_MOD);
        m_phase = ACC_W'(s % PHASE_MOD);
        e_addr  = 10'(longint'(m_phase) / ADDR_DIV);
        m_pend  = 1'b1;
      end
      if (en) m_cnt = (m_cnt + 1) % SAMPLE_DIV;
    end
    if (tw_load) m_tw = tw_in;
  endtask

  initial begin
    reset_model();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) reset_model();
      else     model_edge();
    end
  end

  // ---------------- compare process and pulse log ----------------
  typedef struct {
    int         cyc;
    logic [9:0] addr;
    logic [9:0] smp;
    bit         wrap_before;
  } pulse_t;

  pulse_t pulses[$];
  bit     wrap_prev = 1'b0;
  int     wrap_hits = 0;

  initial begin
    forever begin
      @(negedge clk);
      cyc_no++;
      chk("rom_addr", 32'(rom_addr), 32'(e_addr));
      chk("sample", 32'(sample), 32'(e_sample));
      chk("sample_valid", 32'(sample_valid), 32'(e_valid));
      chk("wrap", 32'(wrap), 32'(e_wrap));
      if (sample_valid) pulses.push_back('{cyc_no, rom_addr, sample, wrap_prev});
      if (wrap) wrap_hits++;
      wrap_prev = wrap;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_with_tw(input logic [ACC_W-1:0] t);
    phase_clr = 1'b1;
    tw_load   = 1'b1;
    tw_in     = t;
    cycles(1);
    phase_clr = 1'b0;
    tw_load   = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++)
      rom_mem[i] = 10'($rtoi(511.5 + 511.0 * $sin(6.283185307179586 * real'(i) / 1024.0)));

    // Reset held with en high, then the first cycle after release.
    cycles(3);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_sample", 32'(sample), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    rst = 1'b0;
    cycles(1);
    chk("rel_addr", 32'(rom_addr), 32'd0);
    chk("rel_valid", 32'(sample_valid), 32'd0);
    pulses.delete();
    cycles(10);
    // Tuning word 0 still yields samples, always at address 0.
    chk("tw0_npulses", 32'(pulses.size()), 32'd2);
    chk("tw0_addr", 32'(pulses[0].addr), 32'd0);
    chk("tw0_sample", 32'(pulses[0].smp), 32'(rom_mem[0]));

    // Sine stepping by one address per sample.
    clear_with_tw(24'h004000);
    pulses.delete();
    cycles(21);
    chk("sine_npulses", 32'(pulses.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      chk("sine_addr", 32'(pulses[k].addr), 32'(k + 1));
      chk("sine_sample", 32'(pulses[k].smp), 32'(rom_mem[k + 1]));
      if (k > 0) chk("sine_period", 32'(pulses[k].cyc - pulses[k-1].cyc), 32'd4);
    end

    // Quarter-turn steps: one wrap on the 4th sample.
    clear_with_tw(24'h400000);
    pulses.delete();
    wrap_hits = 0;
    cycles(17);
    chk("wrap_npulses", 32'(pulses.size()), 32'd4);
    chk("wrap_addr0", 32'(pulses[0].addr), 32'd256);
    chk("wrap_addr1", 32'(pulses[1].addr), 32'd512);
    chk("wrap_addr2", 32'(pulses[2].addr), 32'd768);
    chk("wrap_addr3", 32'(pulses[3].addr), 32'd0);
    chk("wrap_flag2", 32'(pulses[2].wrap_before), 32'd0);
    chk("wrap_flag3", 32'(pulses[3].wrap_before), 32'd1);
    chk("wrap_count", 32'(wrap_hits), 32'd1);

`ifdef DDS_WAVE_SEL_EN
    for (int sel = 1; sel < 4; sel++) begin
      wave_sel = 2'(sel);
      clear_with_tw(24'h400000);
      pulses.delete();
      cycles(17);
      chk("wave_npulses", 32'(pulses.size()), 32'd4);
      if (sel == 1) chk("square_512", 32'(pulses[1].smp), 32'h3FF);
      if (sel == 2) chk("saw_512", 32'(pulses[1].smp), 32'h200);
      if (sel == 3) begin
        chk("tri_512", 32'(pulses[1].smp), 32'h3FF);
        chk("tri_768", 32'(pulses[2].smp), 32'h1FF);
      end
    end
    wave_sel = 2'd0;
`endif

    // phase_clr on the tick edge wins: no sample, address back to 0.
    clear_with_tw(24'h004000);
    pulses.delete();
    cycles(3);
    phase_clr = 1'b1;
    cycles(1);
    phase_clr = 1'b0;
    cycles(2);
    chk("clr_npulses", 32'(pulses.size()), 32'd0);
    chk("clr_addr", 32'(rom_addr), 32'd0);

    // tw_load on the tick edge: that step uses the old word.
    clear_with_tw(24'h004000);
    pulses.delete();
    cycles(3);
    tw_load = 1'b1;
    tw_in   = 24'h100000;
    cycles(1);
    tw_load = 1'b0;
    cycles(5);
    chk("load_npulses", 32'(pulses.size()), 32'd2);
    chk("load_addr0", 32'(pulses[0].addr), 32'd1);
    chk("load_addr1", 32'(pulses[1].addr), 32'd65);

    // Asynchronous reset in the middle of FETCH.
    clear_with_tw(24'h004000);
    cycles(3);
    pulses.delete();
    @(posedge clk);
    #3;
    rst = 1'b1;
    cycles(3);
    chk("rstf_sample", 32'(sample), 32'd0);
    chk("rstf_addr", 32'(rom_addr), 32'd0);
    chk("rstf_npulses", 32'(pulses.size()), 32'd0);
    rst     = 1'b0;
    tw_load = 1'b1;
    tw_in   = 24'h004000;
    cycles(1);
    tw_load = 1'b0;
    cycles(5);
    chk("rstf_restart_n", 32'(pulses.size()), 32'd1);
    chk("rstf_restart_addr", 32'(pulses[0].addr), 32'd1);

    // Randomized mix checked by the model every cycle.
    tw_in   = 24'($urandom);
    tw_load = 1'b1;
    cycles(1);
    for (int i = 0; i < 3000; i++) begin
      en        = ($urandom % 10) != 0;
      phase_clr = ($urandom % 50) == 0;
      tw_load   = ($urandom % 20) == 0;
      tw_in     = 24'($urandom);
      wave_sel  = 2'($urandom);
      cycles(1);
    end
    en        = 1'b1;
    phase_clr = 1'b0;
    tw_load   = 1'b0;
    cycles(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dds_phase_reader.md
# dds_phase_reader

Waveform-synthesis sample engine that reads the 1024 x 10-bit sine lookup ROM.
- A phase accumulator advances by a programmable tuning word once per sample period.
- The top 10 accumulator bits drive the ROM address.
- The ROM word, or a waveform derived from the address, is registered as a 10-bit output sample with a one-cycle valid strobe.
- The block sits between the combinational sine ROM and the DAC/PWM output stage.

## Interface
- ACC_W, default 24: phase accumulator width. Must be at least 10.
- SAMPLE_DIV, default 1000: clk cycles per sample period. Must be at least 2.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable for the sample prescaler.
- tw_load  in  1  load tw_in into the tuning-word register.
- tw_in  in  ACC_W  tuning word (phase increment per sample).
- phase_clr  in  1  synchronous clear of phase and prescaler.
- wave_sel  in  2  waveform select: 0 sine, 1 square, 2 sawtooth, 3 triangle.
- rom_addr  out  10  registered address to the sine ROM.
- rom_data  in  10  ROM read data, combinational from rom_addr.
- sample  out  10  registered output sample, unsigned.
- sample_valid  out  1  one-cycle pulse when sample updates.
- wrap  out  1  one-cycle pulse when the accumulator overflows.

## Operation
- Reset values:
  - acc = 0, tw = 0, div_cnt = 0, state = IDLE.
  - Outputs: rom_addr = 0, sample = 0, sample_valid = 0, wrap = 0.
- Prescaler:
  - div_cnt counts 0 to SAMPLE_DIV-1 while en = 1, and holds while en = 0.
  - tick = en & (div_cnt == SAMPLE_DIV-1).
- State machine:
  - IDLE, on tick:
    - acc <= acc + tw, truncated to ACC_W bits.
    - wrap <= carry out of that add.
    - rom_addr <= (acc + tw)[ACC_W-1 : ACC_W-10].
    - Next state FETCH.
  - FETCH, one cycle:
    - sample <= f(wave_sel, rom_addr, rom_data).
    - sample_valid <= 1.
    - wrap <= 0.
    - Next state IDLE.
  - sample_valid is 0 in every cycle other than the one following FETCH.
- Waveform function, with a = rom_addr:
  - sine: rom_data.
  - square: a[9] ? 10'h3FF : 10'h000.
  - sawtooth: a.
  - triangle: a[9] ? ~{a[8:0],1'b0} : {a[8:0],1'b0}.
- tw_load: tw <= tw_in at the next edge. If it coincides with a tick, that tick uses the old tw.
- phase_clr:
  - acc, div_cnt and rom_addr go to 0, wrap to 0, state to IDLE.
  - Any in-flight FETCH is aborted and produces no sample_valid.
  - Takes priority over tick.
  - sample holds its last value.
- en deasserted mid-FETCH: the FETCH completes normally.
- Tuning word 0: samples keep being produced at a constant address.

## Timing
- Tick to rom_addr update: 1 edge.
- Tick to sample and sample_valid high: 2 edges. sample_valid is high for exactly 1 cycle.
- Sample period: exactly SAMPLE_DIV cycles while en = 1.
- wrap is high during the FETCH cycle of the overflowing sample, one cycle before the matching sample_valid.
- rom_data is sampled in FETCH, one full cycle after rom_addr changes, so the ROM is allowed a full-cycle combinational path.
- rst asserts asynchronously at any point: all registers return to reset values immediately and no partial sample is emitted.

## Configuration
- `DDS_WAVE_SEL_EN` defined:
  - All four waveforms are available via wave_sel.
- `DDS_WAVE_SEL_EN` undefined:
  - The wave_sel port remains but is ignored.
  - sample is always rom_data (sine), and the waveform mux is not built.

## Test plan
Bench parameters: ACC_W = 24, SAMPLE_DIV = 4, behavioural 1024-entry ROM model.
- **Reset:** assert rst with en = 1 → rom_addr = 0, sample = 0, sample_valid = 0, wrap = 0 while rst is high and in the first cycle after release.
- **Sine stepping:** tw = 24'h004000, wave_sel = 0, en = 1 → rom_addr steps 1, 2, 3, …; sample_valid every 4 cycles; sample = rom[addr] at each pulse.
- **Wrap:** tw = 24'h400000 → rom_addr sequence 256, 512, 768, 0; wrap pulses once on the 4th sample, one cycle before its sample_valid.
- **Derived waveforms** (with `DDS_WAVE_SEL_EN`):
  - addr 512: square = 10'h3FF, saw = 10'h200, triangle = 10'h3FF.
  - addr 768: triangle = 10'h1FF.
- **Clear and load priority:**
  - phase_clr asserted on the tick edge → no sample_valid, rom_addr = 0.
  - tw_load coincident with a tick → that step uses the old tw.
- **Reset mid-FETCH:** assert rst during FETCH → sample_valid never asserts and sample = 0; after release, sampling restarts from phase 0.
